// File: rtl/card_dealer_pkg.sv
// Shared constants, state encoding and LFSR step function for the card dealer.
package card_dealer_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned RANK_W    = 4;
  localparam int unsigned SUIT_W    = 2;
  localparam int unsigned CARD_W    = RANK_W + SUIT_W;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StShuf = 2'd1,
    StDeal = 2'd2
  } state_e;

  // One Galois step: shift right, fold the dropped bit back through the taps
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic [15:0] nxt;
    nxt = {1'b0, cur[15:1]};
    if (cur[0]) begin
      nxt = nxt ^ LFSR_TAPS;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Galois LFSR; an all-zero seed would lock up, so it becomes 1.
module card_lfsr
  import card_dealer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_nz;

  assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

  // Advance every cycle regardless of dealer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed_nz;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/card_dealer.sv
// Card dealer: fills a 52-card deck, optionally Fisher-Yates shuffles it, then
// deals one card per pip request.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned SHUFFLE_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pip,
  input  logic              shuffle,
  output logic [RANK_W-1:0] number,
  output logic [SUIT_W-1:0] suits,
  output logic              empty,
  output logic              busy,
  output logic [5:0]        dealt
);

  localparam logic [5:0] LastIdx  = 6'(DECK_SIZE - 1);
  localparam logic [5:0] DeckFull = 6'(DECK_SIZE);

  state_e             state_q;
  logic [5:0]         fill_idx_q;
  logic [5:0]         shuf_idx_q;
  logic [5:0]         dealt_q;
  logic               empty_q;
  logic [RANK_W-1:0]  number_q;
  logic [SUIT_W-1:0]  suits_q;
  logic [CARD_W-1:0]  deck_q [DECK_SIZE];
  logic [15:0]        lfsr_q;
  logic [5:0]         rand_j;
  logic               swap_en;
  logic               deal_en;

  card_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign rand_j  = lfsr_q[5:0];
  // Out-of-range draws (j > i) simply retry on the next LFSR value
  assign swap_en = (state_q == StShuf) && (rand_j <= shuf_idx_q);
  assign deal_en = (state_q == StDeal) && pip && !empty_q && (dealt_q < DeckFull);

  // Deck storage: sequential fill, then in-place swaps; no reset needed
  always_ff @(posedge clk) begin
    if (state_q == StFill) begin
      deck_q[fill_idx_q] <= {fill_idx_q[5:2] + 4'd1, fill_idx_q[1:0]};
    end else if (swap_en) begin
      deck_q[shuf_idx_q] <= deck_q[rand_j];
      deck_q[rand_j]     <= deck_q[shuf_idx_q];
    end
  end

  // Control FSM with registered deal outputs; shuffle request overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFill;
      fill_idx_q <= '0;
      shuf_idx_q <= LastIdx;
      dealt_q    <= '0;
      empty_q    <= 1'b0;
      number_q   <= '0;
      suits_q    <= '0;
    end else if (shuffle) begin
      state_q    <= StFill;
      fill_idx_q <= '0;
      dealt_q    <= '0;
      empty_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          fill_idx_q <= fill_idx_q + 6'd1;
          if (fill_idx_q == LastIdx) begin
            shuf_idx_q <= LastIdx;
            state_q    <= (SHUFFLE_EN != 0) ? StShuf : StDeal;
          end
        end
        StShuf: begin
          if (swap_en) begin
            shuf_idx_q <= shuf_idx_q - 6'd1;
            if (shuf_idx_q == 6'd1) begin
              state_q <= StDeal;
            end
          end
        end
        StDeal: begin
          if (deal_en) begin
            number_q <= deck_q[dealt_q][5:2];
            suits_q  <= deck_q[dealt_q][1:0];
            dealt_q  <= dealt_q + 6'd1;
            if (dealt_q == LastIdx) begin
              empty_q <= 1'b1;
            end
          end
        end
        default: state_q <= StFill;
      endcase
    end
  end

  assign number = number_q;
  assign suits  = suits_q;
  assign empty  = empty_q;
  assign dealt  = dealt_q;
  assign busy   = (state_q != StDeal);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench: an ordered-deck instance (SHUFFLE_EN=0) driven from a vector
// table, and a shuffling instance checked against a reference Fisher-Yates model.
module tb_card_dealer;

  localparam logic [15:0] Seed = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n;
  logic [1:0]      pip;
  logic [1:0]      shuffle;
  logic [1:0]      empty;
  logic [1:0]      busy;
  logic [1:0][3:0] number;
  logic [1:0][1:0] suits;
  logic [1:0][5:0] dealt;

  card_dealer #(.SEED(Seed), .SHUFFLE_EN(0)) u_ord (
    .clk     (clk),
    .rst_n   (rst_n[0]),
    .pip     (pip[0]),
    .shuffle (shuffle[0]),
    .number  (number[0]),
    .suits   (suits[0]),
    .empty   (empty[0]),
    .busy    (busy[0]),
    .dealt   (dealt[0])
  );

  card_dealer #(.SEED(Seed), .SHUFFLE_EN(1)) u_shf (
    .clk     (clk),
    .rst_n   (rst_n[1]),
    .pip     (pip[1]),
    .shuffle (shuffle[1]),
    .number  (number[1]),
    .suits   (suits[1]),
    .empty   (empty[1]),
    .busy    (busy[1]),
    .dealt   (dealt[1])
  );

  typedef struct {
    logic       pip;
    logic       shuf;
    logic [3:0] num;
    logic [1:0] st;
    logic [5:0] dl;
    logic       em;
    logic       bz;
  } vec_t;

  vec_t       vecs [14];
  int         n_vec;
  int         n_err;
  logic [5:0] model_deck [52];
  int         model_shuf_cycles;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int d, input int num, input int st,
                           input int dl, input int em, input int bz);
    check({tag, " number"}, int'(number[d]), num);
    check({tag, " suits"},  int'(suits[d]),  st);
    check({tag, " dealt"},  int'(dealt[d]),  dl);
    check({tag, " empty"},  int'(empty[d]),  em);
    check({tag, " busy"},   int'(busy[d]),   bz);
  endtask

  function automatic logic [15:0] step(input logic [15:0] l);
    logic [15:0] n;
    n = {1'b0, l[15:1]};
    if (l[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // Reference deal order: 52 fill cycles advance the LFSR, then one draw per cycle
  task automatic build_model();
    logic [15:0] l;
    logic [5:0]  j;
    logic [5:0]  t;
    int          i;
    for (int k = 0; k < 52; k++) model_deck[k] = 6'(((k / 4 + 1) << 2) | (k % 4));
    l = Seed;
    for (int k = 0; k < 52; k++) l = step(l);
    i = 51;
    model_shuf_cycles = 0;
    while (i > 0) begin
      j = l[5:0];
      model_shuf_cycles++;
      if (int'(j) <= i) begin
        t = model_deck[i];
        model_deck[i] = model_deck[j];
        model_deck[j] = t;
        i--;
      end
      l = step(l);
    end
  endtask

  // Count edges until busy drops; optionally hold pip high for a while during busy
  task automatic wait_idle(input int d, input int limit, input bit pip_early, output int cnt);
    cnt = 0;
    while (cnt < limit) begin
      pip[d] = pip_early && (cnt >= 2) && (cnt < 12);
      @(negedge clk);
      cnt++;
      if (!busy[d]) break;
    end
    pip[d] = 1'b0;
  endtask

  task automatic deal(input int d);
    pip[d] = 1'b1;
    @(negedge clk);
    pip[d] = 1'b0;
  endtask

  task automatic deal_vs_model(input string tag);
    int seen [64];
    int ones;
    int differs;
    for (int c = 0; c < 64; c++) seen[c] = 0;
    differs = 0;
    for (int k = 0; k < 52; k++) begin
      deal(1);
      check({tag, " rank"}, int'(number[1]), int'(model_deck[k][5:2]));
      check({tag, " suit"}, int'(suits[1]),  int'(model_deck[k][1:0]));
      seen[{number[1], suits[1]}]++;
      if ({number[1], suits[1]} != 6'(((k / 4 + 1) << 2) | (k % 4))) differs = 1;
    end
    ones = 0;
    for (int c = 0; c < 64; c++) if (seen[c] == 1) ones++;
    check({tag, " distinct cards"}, ones, 52);
    check({tag, " order differs"}, differs, 1);
    check({tag, " dealt"}, int'(dealt[1]), 52);
    check({tag, " empty"}, int'(empty[1]), 1);
  endtask

  initial begin
    int cnt;
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 2'b00;
    pip     = 2'b00;
    shuffle = 2'b00;
    build_model();

    //               pip   shuf  num   st    dealt  em    bz
    vecs[0]  = '{1'b1, 1'b0, 4'd1, 2'd0, 6'd1,  1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 4'd1, 2'd1, 6'd2,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd1, 2'd1, 6'd2,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'd1, 2'd2, 6'd3,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 4'd1, 2'd3, 6'd4,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 4'd2, 2'd0, 6'd5,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 4'd2, 2'd0, 6'd5,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd2, 2'd1, 6'd6,  1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 4'd2, 2'd2, 6'd7,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 4'd2, 2'd3, 6'd8,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'd3, 2'd0, 6'd9,  1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 4'd3, 2'd1, 6'd10, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'd3, 2'd1, 6'd0,  1'b0, 1'b1};  // shuffle beats pip
    vecs[13] = '{1'b0, 1'b0, 4'd3, 2'd1, 6'd0,  1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check_out("reset ord", 0, 0, 0, 0, 0, 1);
    check_out("reset shf", 1, 0, 0, 0, 0, 1);

    // Ordered instance: pips during fill are dropped
    rst_n[0] = 1'b1;
    wait_idle(0, 200, 1'b1, cnt);
    check("ord fill cycles", cnt, 52);
    check("ord pip while busy dealt", int'(dealt[0]), 0);
    check("ord pip while busy number", int'(number[0]), 0);

    for (int v = 0; v < 14; v++) begin
      pip[0]     = vecs[v].pip;
      shuffle[0] = vecs[v].shuf;
      @(negedge clk);
      pip[0]     = 1'b0;
      shuffle[0] = 1'b0;
      check_out($sformatf("vec%0d", v), 0, int'(vecs[v].num), int'(vecs[v].st),
                int'(vecs[v].dl), int'(vecs[v].em), int'(vecs[v].bz));
    end

    wait_idle(0, 200, 1'b0, cnt);
    check("ord refill cycles", cnt, 51);
    for (int k = 0; k < 52; k++) begin
      deal(0);
      check($sformatf("ord card%0d rank", k), int'(number[0]), k / 4 + 1);
      check($sformatf("ord card%0d suit", k), int'(suits[0]), k % 4);
      check($sformatf("ord card%0d dealt", k), int'(dealt[0]), k + 1);
      check($sformatf("ord card%0d empty", k), int'(empty[0]), (k == 51) ? 1 : 0);
    end
    deal(0);
    check_out("ord pip on empty", 0, 13, 3, 52, 1, 0);
    shuffle[0] = 1'b1;
    @(negedge clk);
    shuffle[0] = 1'b0;
    check_out("ord shuffle from empty", 0, 13, 3, 0, 0, 1);

    // Shuffling instance against the reference model
    rst_n[1] = 1'b1;
    wait_idle(1, 5000, 1'b0, cnt);
    check("shf busy cycles", cnt, 52 + model_shuf_cycles);
    deal_vs_model("run1");

    // Reshuffle, then abort with reset mid-SHUF
    shuffle[1] = 1'b1;
    @(negedge clk);
    shuffle[1] = 1'b0;
    repeat (60) @(negedge clk);
    check_out("shf mid-shuffle hold", 1, int'(model_deck[51][5:2]),
              int'(model_deck[51][1:0]), 0, 0, 1);
    #2 rst_n[1] = 1'b0;
    #1 check_out("shf async reset", 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    wait_idle(1, 5000, 1'b0, cnt);
    check("shf busy cycles after reset", cnt, 52 + model_shuf_cycles);
    deal_vs_model("run2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
